// File: rtl/icache_fill_controller.sv
// Instruction-cache page refill engine: reads 64 words, one outstanding read at a time,
// and writes each word into the cache; aborts the fill if a read exceeds TIMEOUT cycles.
module icache_fill_controller #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fill_req,
  input  logic [15:0] fill_base,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fill_err,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  input  logic [15:0] ext_data,
  input  logic        ext_valid,
  output logic [15:0] mem_offset,
  output logic [5:0]  mem_inst_addr,
  output logic [15:0] mem_inst_bus,
  output logic        mem_we
);

  // state   | meaning
  // S_IDLE  | waiting for fill_req; done/err pulse shows here after a fill ends
  // S_REQ   | ext_rd strobe for word count
  // S_WAIT  | waiting for ext_valid, timeout counter running
  // S_WRITE | mem_we strobe for word count
  // S_DONE  | last word written; fill_done follows in IDLE
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      base_q, base_d;
  logic [5:0]      count_q, count_d;
  logic [TO_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic [15:0]     data_q, data_d;
  logic            ext_rd_q, ext_rd_d;
  logic            mem_we_q, mem_we_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  assign tmr_inc = tmr_q + TO_W'(1);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    tmr_d    = tmr_q;
    data_d   = data_q;
    ext_rd_d = 1'b0;
    mem_we_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          base_d   = fill_base[15:6];
          count_d  = 6'd0;
          tmr_d    = '0;
          ext_rd_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (ext_valid) begin
          data_d   = ext_data;
          mem_we_d = 1'b1;
          state_d  = S_WRITE;
        end else begin
          tmr_d = tmr_inc;
          if (tmr_inc == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (count_q == 6'd63) begin
          state_d = S_DONE;
        end else begin
          count_d  = count_q + 6'd1;
          tmr_d    = '0;
          ext_rd_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      tmr_q    <= '0;
      data_q   <= '0;
      ext_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
      data_q   <= data_d;
      ext_rd_q <= ext_rd_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // base occupies [15:6] and count [5:0], so the read address can never carry into the page
  assign ext_addr      = {base_q, count_q};
  assign mem_offset    = {base_q, 6'd0};
  assign mem_inst_addr = count_q;
  assign mem_inst_bus  = data_q;
  assign ext_rd        = ext_rd_q;
  assign mem_we        = mem_we_q;
  assign fill_done     = done_q;
  assign fill_err      = err_q;
  assign fill_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_icache_fill_controller.sv
// Bench for icache_fill_controller: external-memory model with random latency, write scoreboard
// filled from the page/word rules, and directed fill, timeout, mid-fill request and reset scenarios.
module tb_icache_fill_controller;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 8;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        fill_req  = 1'b0;
  logic [15:0] fill_base = '0;
  logic        fill_busy, fill_done, fill_err, ext_rd, mem_we;
  logic [15:0] ext_addr, mem_offset, mem_inst_bus;
  logic [5:0]  mem_inst_addr;
  logic [15:0] ext_data  = '0;
  logic        ext_valid = 1'b0;

  always #5 clock = ~clock;

  icache_fill_controller #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset), .fill_req(fill_req), .fill_base(fill_base),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
    .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_data(ext_data), .ext_valid(ext_valid),
    .mem_offset(mem_offset), .mem_inst_addr(mem_inst_addr), .mem_inst_bus(mem_inst_bus),
    .mem_we(mem_we)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  // ---------------- external memory model ----------------
  int          data_mode   = 0;
  int          withhold    = -1;
  int          lat_min     = 1;
  int          lat_max     = 1;
  bit          spurious_en = 1'b0;
  bit          mem_pending = 1'b0;
  int          mem_cnt     = 0;
  logic [15:0] mem_addr_l  = '0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    if (data_mode == 0) return 16'hA000 + {10'd0, a[5:0]};
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  always @(negedge clock) begin
    ext_valid = 1'b0;
    if (reset) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          ext_valid   = 1'b1;
          ext_data    = mem_word(mem_addr_l);
          mem_pending = 1'b0;
        end
      end else if (spurious_en && (ext_rd || mem_we || !fill_busy) && $urandom_range(0, 1) == 1) begin
        ext_valid = 1'b1;
        ext_data  = 16'($urandom);
      end
      if (ext_rd) begin
        check("one_outstanding", 32'(mem_pending), 0);
        if (int'(ext_addr[5:0]) != withhold) begin
          mem_pending = 1'b1;
          mem_cnt     = $urandom_range(lat_min, lat_max);
          mem_addr_l  = ext_addr;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed { logic [5:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] exp_base   = '0;
  int          exp_rd_idx = 0;
  int          done_seen  = 0;
  int          err_seen   = 0;
  int          done_cyc   = 0;
  int          err_cyc    = 0;
  int          rd_cyc     = 0;
  int          accept_cyc = 0;
  logic [3:0]  prev_p     = '0;

  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          fail("wr_extra", $sformatf("unexpected write addr %0d data %0h", mem_inst_addr, mem_inst_bus));
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_inst_addr), 32'(e.a));
          check("wr_data", 32'(mem_inst_bus), 32'(e.d));
        end
        check("wr_offset", 32'(mem_offset), 32'(exp_base));
      end
      if (ext_rd) begin
        check("rd_addr", 32'(ext_addr), 32'(exp_base | 16'(exp_rd_idx)));
        exp_rd_idx++;
        rd_cyc = cyc;
      end
      if (fill_done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (fill_err) begin
        err_seen++;
        err_cyc = cyc;
      end
      if (|({ext_rd, mem_we, fill_done, fill_err} & prev_p))
        fail("pulse_width", $sformatf("rd/we/done/err=%b high two cycles", {ext_rd, mem_we, fill_done, fill_err}));
      prev_p = {ext_rd, mem_we, fill_done, fill_err};
    end else begin
      prev_p = '0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_fill(input logic [15:0] b, input int mode, input int wh, input int lmin, input int lmax);
    int n;
    @(negedge clock);
    data_mode  = mode;
    withhold   = wh;
    lat_min    = lmin;
    lat_max    = lmax;
    exp_base   = {b[15:6], 6'd0};
    exp_rd_idx = 0;
    n = (wh < 0) ? 64 : wh;
    for (int i = 0; i < n; i++) exp_q.push_back({6'(i), mem_word(exp_base | 16'(i))});
    fill_base  = b;
    fill_req   = 1'b1;
    accept_cyc = cyc + 1;
    @(negedge clock);
    fill_req  = 1'b0;
    fill_base = 16'($urandom);
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n;
    n = 0;
    while (done_seen == d0 && err_seen == e0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) fail("wait_end", "no fill_done or fill_err within 3000 cycles");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 32'({fill_busy, fill_done, fill_err, ext_rd, mem_we}), 0);
    check({tag, "_addr"}, {ext_addr, mem_offset}, 0);
    check({tag, "_data"}, 32'({mem_inst_addr, mem_inst_bus}), 0);
  endtask

  initial begin
    int d0, e0, n;
    logic [15:0] b;

    // reset state
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clock);

    // basic fill, latency 1, completion timing
    d0 = done_seen; e0 = err_seen;
    start_fill(16'h1234, 0, -1, 1, 1);
    wait_end(d0, e0);
    check("t1_done_count", done_seen, d0 + 1);
    check("t1_err_count", err_seen, e0);
    check("t1_done_latency", done_cyc - accept_cyc, 193);
    check("t1_writes_left", exp_q.size(), 0);
    check("t1_offset", 32'(mem_offset), 32'h1200);
    @(negedge clock);
    check("t1_busy_after", 32'(fill_busy), 0);

    // random latencies up to the timeout boundary, spurious ext_valid outside WAIT
    spurious_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = 16'($urandom);
      d0 = done_seen; e0 = err_seen;
      start_fill(b, 1, -1, 1, TIMEOUT);
      wait_end(d0, e0);
      check("t2_done_count", done_seen, d0 + 1);
      check("t2_err_count", err_seen, e0);
      check("t2_writes_left", exp_q.size(), 0);
      check("t2_offset", 32'(mem_offset), 32'({b[15:6], 6'd0}));
    end
    spurious_en = 1'b0;

    // read of word 5 never answered -> timeout abort
    d0 = done_seen; e0 = err_seen;
    start_fill(16'hBEEF, 0, 5, 1, 2);
    wait_end(d0, e0);
    check("t3_err_count", err_seen, e0 + 1);
    check("t3_done_count", done_seen, d0);
    check("t3_writes_left", exp_q.size(), 0);
    check("t3_rd_count", exp_rd_idx, 6);
    check("t3_err_latency", err_cyc - rd_cyc, TIMEOUT + 1);
    check("t3_offset", 32'(mem_offset), 32'hBEC0);
    repeat (5) @(negedge clock);
    check("t3_busy_after", 32'(fill_busy), 0);
    check("t3_err_once", err_seen, e0 + 1);

    // fill_req with a different base while busy is ignored
    d0 = done_seen; e0 = err_seen;
    start_fill(16'h4000, 0, -1, 1, 3);
    repeat (20) @(negedge clock);
    fill_req  = 1'b1;
    fill_base = 16'h8880;
    repeat (10) begin
      @(negedge clock);
      check("t4_offset_hold", 32'(mem_offset), 32'h4000);
    end
    fill_req = 1'b0;
    wait_end(d0, e0);
    check("t4_done_count", done_seen, d0 + 1);
    check("t4_writes_left", exp_q.size(), 0);
    check("t4_offset", 32'(mem_offset), 32'h4000);
    d0 = done_seen;
    start_fill(16'h8880, 1, -1, 1, 2);
    wait_end(d0, e0);
    check("t4_second_done", done_seen, d0 + 1);
    check("t4_second_offset", 32'(mem_offset), 32'h8880);

    // reset while waiting for word 30
    d0 = done_seen; e0 = err_seen;
    start_fill(16'h2C40, 1, -1, 3, 3);
    n = 0;
    while (!(ext_rd && ext_addr[5:0] == 6'd30) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) fail("t5_reach_word30", "read of word 30 never issued");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero("t5_rst");
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clock);
    check("t5_no_done", done_seen, d0);
    check("t5_no_err", err_seen, e0);
    check("t5_idle_busy", 32'(fill_busy), 0);
    start_fill(16'h0A80, 0, -1, 1, 2);
    wait_end(d0, e0);
    check("t5_restart_done", done_seen, d0 + 1);
    check("t5_restart_writes_left", exp_q.size(), 0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    fail("watchdog", "simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
